// File: rtl/csr_excp_unit.sv
// csr_excp_unit: LoongArch CSR file with exception entry/return, fetch redirect PC and interrupt request.
// The constant timer (TCFG/TVAL/TICLR, ESTAT.IS[11]) exists only when CSR_TIMER_EN is defined.
module csr_excp_unit #(
    parameter int          TIMER_W = 32,
    parameter logic [31:0] TID_RST = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        excp_flush,
    input  logic        ertn_flush,
    input  logic [31:0] csr_era,
    input  logic [5:0]  csr_ecode,
    input  logic [8:0]  csr_esubcode,
    input  logic        va_error,
    input  logic [31:0] bad_va,
    input  logic        excp_tlbrefill,
    input  logic        we0,
    input  logic        we1,
    input  logic [13:0] waddr0,
    input  logic [13:0] waddr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic [13:0] raddr,
    output logic [31:0] rdata,
    input  logic [7:0]  hw_int,
    input  logic        ipi,
    output logic [31:0] redirect_pc,
    output logic        int_req,
    output logic [1:0]  plv,
    output logic        da
);
    localparam logic [13:0] A_CRMD   = 14'h0;
    localparam logic [13:0] A_PRMD   = 14'h1;
    localparam logic [13:0] A_ECFG   = 14'h4;
    localparam logic [13:0] A_ESTAT  = 14'h5;
    localparam logic [13:0] A_ERA    = 14'h6;
    localparam logic [13:0] A_BADV   = 14'h7;
    localparam logic [13:0] A_EENTRY = 14'hC;
    localparam logic [13:0] A_SAVE0  = 14'h30;
    localparam logic [13:0] A_TID    = 14'h40;
    localparam logic [13:0] A_TCFG   = 14'h41;
    localparam logic [13:0] A_TVAL   = 14'h42;
    localparam logic [13:0] A_TICLR  = 14'h44;
    localparam logic [13:0] A_TLBRE  = 14'h88;

    logic [31:0] r_crmd, r_prmd, r_ecfg, r_estat, r_era, r_badv, r_eentry, r_tid, r_tlbrentry;
    logic [31:0] w_crmd, w_prmd, w_ecfg, w_estat, w_era, w_badv, w_eentry, w_tid, w_tlbrentry;
    logic [31:0] r_save [4];
    logic [31:0] w_save [4];
    logic               w_is11;
    logic [31:0]        w_tcfg_rd;
    logic [TIMER_W-1:0] w_tval_rd;

    // Port0 is the older instruction, so port1 is applied last and wins on overlap.
    function automatic logic [31:0] wr(input logic [31:0] cur, input logic [13:0] a, input logic [31:0] m);
        logic [31:0] v;
        v = cur;
        if (we0 && waddr0 == a) v = (v & ~m) | (wdata0 & m);
        if (we1 && waddr1 == a) v = (v & ~m) | (wdata1 & m);
        return v;
    endfunction

    always_comb begin
        w_crmd      = wr(r_crmd, A_CRMD, 32'h0000_01FF);
        w_prmd      = wr(r_prmd, A_PRMD, 32'h0000_0007);
        w_ecfg      = wr(r_ecfg, A_ECFG, 32'h0000_1BFF);
        w_estat     = wr(r_estat, A_ESTAT, 32'h0000_0003);
        w_era       = wr(r_era, A_ERA, 32'hFFFF_FFFF);
        w_badv      = wr(r_badv, A_BADV, 32'hFFFF_FFFF);
        w_eentry    = wr(r_eentry, A_EENTRY, 32'hFFFF_FFC0);
        w_tid       = wr(r_tid, A_TID, 32'hFFFF_FFFF);
        w_tlbrentry = wr(r_tlbrentry, A_TLBRE, 32'hFFFF_FFC0);
        for (int i = 0; i < 4; i++) w_save[i] = wr(r_save[i], A_SAVE0 + 14'(i), 32'hFFFF_FFFF);
        // Exception/ertn bookkeeping overrides port writes only on the fields it owns.
        if (excp_flush) begin
            w_prmd[2:0]    = r_crmd[2:0];
            w_crmd[2:0]    = 3'b000;
            w_era          = csr_era;
            w_estat[30:16] = {csr_esubcode, csr_ecode};
            if (va_error) w_badv = bad_va;
            if (excp_tlbrefill) w_crmd[4:3] = 2'b01;
        end else if (ertn_flush) begin
            w_crmd[2:0] = r_prmd[2:0];
            if (r_estat[21:16] == 6'h3F) w_crmd[4:3] = 2'b10;
        end
        w_estat[12:2] = {ipi, w_is11, 1'b0, hw_int};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_crmd      <= 32'h8;
            r_prmd      <= '0;
            r_ecfg      <= '0;
            r_estat     <= '0;
            r_era       <= '0;
            r_badv      <= '0;
            r_eentry    <= '0;
            r_tid       <= TID_RST;
            r_tlbrentry <= '0;
            for (int i = 0; i < 4; i++) r_save[i] <= '0;
        end else begin
            r_crmd      <= w_crmd;
            r_prmd      <= w_prmd;
            r_ecfg      <= w_ecfg;
            r_estat     <= w_estat;
            r_era       <= w_era;
            r_badv      <= w_badv;
            r_eentry    <= w_eentry;
            r_tid       <= w_tid;
            r_tlbrentry <= w_tlbrentry;
            for (int i = 0; i < 4; i++) r_save[i] <= w_save[i];
        end
    end

`ifdef CSR_TIMER_EN
    logic [31:0]        r_tcfg, w_tcfg;
    logic [TIMER_W-1:0] r_tval;
    logic               w_tcfg_we, w_expire, w_clr;

    assign w_tcfg    = wr(r_tcfg, A_TCFG, 32'hFFFF_FFFF);
    assign w_tcfg_we = (we0 && waddr0 == A_TCFG) || (we1 && waddr1 == A_TCFG);
    assign w_clr     = (we1 && waddr1 == A_TICLR) ? wdata1[0] : (we0 && waddr0 == A_TICLR && wdata0[0]);
    assign w_expire  = r_tcfg[0] && r_tval == TIMER_W'(1);
    // An expiry in the same cycle as a TICLR write still leaves the interrupt pending.
    assign w_is11    = w_expire || (r_estat[11] && !w_clr);
    assign w_tcfg_rd = r_tcfg;
    assign w_tval_rd = r_tval;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcfg <= '0;
            r_tval <= '0;
        end else begin
            r_tcfg <= w_tcfg;
            r_tval <= w_tcfg_we ? {w_tcfg[TIMER_W-1:2], 2'b00} :
                      w_expire ? (r_tcfg[1] ? {r_tcfg[TIMER_W-1:2], 2'b00} : '0) :
                      (r_tcfg[0] && r_tval != '0) ? r_tval - TIMER_W'(1) : r_tval;
        end
    end
`else
    assign w_is11    = 1'b0;
    assign w_tcfg_rd = '0;
    assign w_tval_rd = '0;
`endif

    always_comb begin
        rdata = '0;
        case (raddr)
            A_CRMD:         rdata = r_crmd;
            A_PRMD:         rdata = r_prmd;
            A_ECFG:         rdata = r_ecfg;
            A_ESTAT:        rdata = r_estat;
            A_ERA:          rdata = r_era;
            A_BADV:         rdata = r_badv;
            A_EENTRY:       rdata = r_eentry;
            A_SAVE0:        rdata = r_save[0];
            A_SAVE0 + 14'd1: rdata = r_save[1];
            A_SAVE0 + 14'd2: rdata = r_save[2];
            A_SAVE0 + 14'd3: rdata = r_save[3];
            A_TID:          rdata = r_tid;
            A_TCFG:         rdata = w_tcfg_rd;
            A_TVAL:         rdata = 32'(w_tval_rd);
            A_TLBRE:        rdata = r_tlbrentry;
            default:        rdata = '0;
        endcase
    end

    assign redirect_pc = excp_flush ? (excp_tlbrefill ? r_tlbrentry : r_eentry) : ertn_flush ? r_era : 32'h0;
    assign int_req     = r_crmd[2] & |(r_estat[12:0] & r_ecfg[12:0]);
    assign plv         = r_crmd[1:0];
    assign da          = r_crmd[3];
endmodule

// File: tb/tb_csr_excp_unit.sv
// tb_csr_excp_unit: directed scenarios plus randomized traffic checked against an address-keyed CSR model.
`timescale 1ns/100ps
module tb_csr_excp_unit;
`ifdef CSR_TIMER_EN
    localparam bit TIMER_ON = 1'b1;
`else
    localparam bit TIMER_ON = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        excp_flush = 1'b0, ertn_flush = 1'b0, va_error = 1'b0, excp_tlbrefill = 1'b0;
    logic [31:0] csr_era = '0, bad_va = '0, wdata0 = '0, wdata1 = '0;
    logic [5:0]  csr_ecode = '0;
    logic [8:0]  csr_esubcode = '0;
    logic        we0 = 1'b0, we1 = 1'b0, ipi = 1'b0;
    logic [13:0] waddr0 = '0, waddr1 = '0, raddr = '0;
    logic [7:0]  hw_int = '0;
    logic [31:0] rdata, redirect_pc, v;
    logic        int_req, da;
    logic [1:0]  plv;
    int          n_total = 0, n_pass = 0;
    bit   [31:0] m [int];
    int          addr_tab [19] = '{'h0, 'h1, 'h4, 'h5, 'h6, 'h7, 'hC, 'h30, 'h31, 'h32, 'h33,
                                   'h40, 'h41, 'h42, 'h44, 'h88, 'h2, 'h43, 'h100};

    csr_excp_unit dut (
        .clk(clk), .rst(rst), .excp_flush(excp_flush), .ertn_flush(ertn_flush),
        .csr_era(csr_era), .csr_ecode(csr_ecode), .csr_esubcode(csr_esubcode),
        .va_error(va_error), .bad_va(bad_va), .excp_tlbrefill(excp_tlbrefill),
        .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1), .wdata0(wdata0), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata), .hw_int(hw_int), .ipi(ipi),
        .redirect_pc(redirect_pc), .int_req(int_req), .plv(plv), .da(da)
    );

    always #5 clk = ~clk;

    function automatic bit [31:0] wmask(int a);
        case (a)
            'h0: return 32'h1FF;
            'h1: return 32'h7;
            'h4: return 32'h1BFF;
            'h5: return 32'h3;
            'h6, 'h7, 'h30, 'h31, 'h32, 'h33, 'h40: return 32'hFFFF_FFFF;
            'hC, 'h88: return 32'hFFFF_FFC0;
            'h41: return TIMER_ON ? 32'hFFFF_FFFF : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    function automatic void model_reset();
        m.delete();
        foreach (addr_tab[i]) if (addr_tab[i] < 'h88 && addr_tab[i] != 'h44 && addr_tab[i] != 'h2 && addr_tab[i] != 'h43) m[addr_tab[i]] = 0;
        m['h88] = 0;
        m['h0] = 32'h8;
    endfunction

    function automatic bit [31:0] model_read(int a);
        return m.exists(a) ? m[a] : 32'h0;
    endfunction

    // Apply one clock edge: program-order port writes, then timer, then exception/ertn rules.
    function automatic void model_step();
        bit [31:0] oc = m['h0], op = m['h1], oe = m['h5], ot = m['h41], ov = m['h42];
        bit [31:0] d [2], c, e;
        int        a [2];
        bit        w [2];
        bit        expire, clr = 0, load = 0, is11;
        w[0] = we0; a[0] = int'(waddr0); d[0] = wdata0;
        w[1] = we1; a[1] = int'(waddr1); d[1] = wdata1;
        expire = TIMER_ON && ot[0] && ov == 1;
        for (int p = 0; p < 2; p++) begin
            if (!w[p]) continue;
            if (a[p] == 'h44) clr = TIMER_ON && d[p][0];
            else if (wmask(a[p]) != 0) begin
                m[a[p]] = (m[a[p]] & ~wmask(a[p])) | (d[p] & wmask(a[p]));
                if (a[p] == 'h41) load = 1;
            end
        end
        if (load) m['h42] = m['h41] & ~32'h3;
        else if (expire) m['h42] = ot[1] ? (ot & ~32'h3) : 0;
        else if (TIMER_ON && ot[0] && ov != 0) m['h42] = ov - 1;
        is11 = expire || (oe[11] && !clr);
        c = m['h0];
        e = m['h5];
        if (excp_flush) begin
            m['h1] = {29'h0, oc[2:0]};
            c[2:0] = 3'b000;
            if (excp_tlbrefill) begin c[3] = 1; c[4] = 0; end
            m['h6] = csr_era;
            e[21:16] = csr_ecode;
            e[30:22] = csr_esubcode;
            if (va_error) m['h7] = bad_va;
        end else if (ertn_flush) begin
            c[2:0] = op[2:0];
            if (oe[21:16] == 6'h3F) begin c[3] = 0; c[4] = 1; end
        end
        e[9:2] = hw_int;
        e[10] = 0;
        e[11] = is11;
        e[12] = ipi;
        m['h0] = c;
        m['h5] = e;
    endfunction

    function automatic bit model_int();
        bit [31:0] c = m['h0], e = m['h5], f = m['h4];
        return c[2] && |(e[12:0] & f[12:0]);
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        #1;
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; excp_flush = 0; ertn_flush = 0; va_error = 0; excp_tlbrefill = 0;
        hw_int = 0; ipi = 0;
    endtask

    task automatic rd(input logic [13:0] a, output logic [31:0] val);
        raddr = a;
        #1;
        val = rdata;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        rd(14'h0, v);
        n_total++; if (v !== 32'h8) $display("FAIL reset_crmd got %h exp %h", v, 32'h8); else n_pass++;
        rd(14'h5, v);
        n_total++; if (v !== 32'h0) $display("FAIL reset_estat got %h exp %h", v, 32'h0); else n_pass++;
        rd(14'h40, v);
        n_total++; if (v !== 32'h0) $display("FAIL reset_tid got %h exp %h", v, 32'h0); else n_pass++;
        n_total++; if (int_req !== 1'b0) $display("FAIL reset_int_req got %b exp 0", int_req); else n_pass++;
        n_total++; if (redirect_pc !== 32'h0) $display("FAIL reset_redirect got %h exp 0", redirect_pc); else n_pass++;
        n_total++; if ({da, plv} !== 3'b100) $display("FAIL reset_da_plv got %b exp 100", {da, plv}); else n_pass++;
    endtask

    task automatic test_excp();
        we0 = 1; waddr0 = 14'h0; wdata0 = 32'h7;
        we1 = 1; waddr1 = 14'hC; wdata1 = 32'h1C00_8000;
        tick();
        idle();
        excp_flush = 1; csr_era = 32'h1C00_0100; csr_ecode = 6'hB; csr_esubcode = 9'h0;
        #1;
        n_total++; if (redirect_pc !== 32'h1C00_8000) $display("FAIL excp_redirect got %h exp %h", redirect_pc, 32'h1C00_8000); else n_pass++;
        tick();
        idle();
        rd(14'h0, v);
        n_total++; if (v[2:0] !== 3'b000) $display("FAIL excp_crmd got %h exp 0", v[2:0]); else n_pass++;
        rd(14'h1, v);
        n_total++; if (v[2:0] !== 3'b111) $display("FAIL excp_prmd got %h exp 7", v[2:0]); else n_pass++;
        rd(14'h6, v);
        n_total++; if (v !== 32'h1C00_0100) $display("FAIL excp_era got %h exp %h", v, 32'h1C00_0100); else n_pass++;
        rd(14'h5, v);
        n_total++; if (v[21:16] !== 6'hB) $display("FAIL excp_ecode got %h exp b", v[21:16]); else n_pass++;
    endtask

    task automatic test_ertn();
        ertn_flush = 1;
        #1;
        n_total++; if (redirect_pc !== 32'h1C00_0100) $display("FAIL ertn_redirect got %h exp %h", redirect_pc, 32'h1C00_0100); else n_pass++;
        tick();
        idle();
        rd(14'h0, v);
        n_total++; if (v[2:0] !== 3'b111) $display("FAIL ertn_crmd got %h exp 7", v[2:0]); else n_pass++;
        n_total++; if (plv !== 2'd3) $display("FAIL ertn_plv got %0d exp 3", plv); else n_pass++;
    endtask

    task automatic test_tlbrefill();
        we0 = 1; waddr0 = 14'h88; wdata0 = 32'h1C00_F000;
        tick();
        idle();
        excp_flush = 1; excp_tlbrefill = 1; csr_ecode = 6'h3F; va_error = 1;
        bad_va = 32'hDEAD_B000; csr_era = 32'h1C00_0200;
        #1;
        n_total++; if (redirect_pc !== 32'h1C00_F000) $display("FAIL tlbr_redirect got %h exp %h", redirect_pc, 32'h1C00_F000); else n_pass++;
        tick();
        idle();
        rd(14'h7, v);
        n_total++; if (v !== 32'hDEAD_B000) $display("FAIL tlbr_badv got %h exp %h", v, 32'hDEAD_B000); else n_pass++;
        rd(14'h0, v);
        n_total++; if (v[4:3] !== 2'b01 || da !== 1'b1) $display("FAIL tlbr_pg_da got %b/%b exp 01/1", v[4:3], da); else n_pass++;
        ertn_flush = 1;
        #1;
        n_total++; if (redirect_pc !== 32'h1C00_0200) $display("FAIL tlbr_ertn_redirect got %h exp %h", redirect_pc, 32'h1C00_0200); else n_pass++;
        tick();
        idle();
        rd(14'h0, v);
        n_total++; if (v[4:3] !== 2'b10 || da !== 1'b0) $display("FAIL tlbr_ertn_pg_da got %b/%b exp 10/0", v[4:3], da); else n_pass++;
    endtask

    task automatic test_dual_write();
        we0 = 1; waddr0 = 14'h30; wdata0 = 32'h1111;
        we1 = 1; waddr1 = 14'h30; wdata1 = 32'h2222;
        tick();
        idle();
        rd(14'h30, v);
        n_total++; if (v !== 32'h2222) $display("FAIL dual_save0 got %h exp %h", v, 32'h2222); else n_pass++;
        we0 = 1; waddr0 = 14'h31; wdata0 = 32'hABCD;
        we1 = 1; waddr1 = 14'h6; wdata1 = 32'h5555;
        excp_flush = 1; csr_era = 32'h1C00_0300; csr_ecode = 6'h1;
        tick();
        idle();
        rd(14'h31, v);
        n_total++; if (v !== 32'hABCD) $display("FAIL dual_save1 got %h exp %h", v, 32'hABCD); else n_pass++;
        rd(14'h6, v);
        n_total++; if (v !== 32'h1C00_0300) $display("FAIL dual_era got %h exp %h", v, 32'h1C00_0300); else n_pass++;
        rd(14'h2, v);
        n_total++; if (v !== 32'h0) $display("FAIL unimpl_read got %h exp 0", v); else n_pass++;
    endtask

    task automatic test_timer();
        do_reset();
        we0 = 1; waddr0 = 14'h0; wdata0 = 32'h4;
        we1 = 1; waddr1 = 14'h4; wdata1 = 32'h800;
        tick();
        idle();
        we0 = 1; waddr0 = 14'h41; wdata0 = 32'h13;
        tick();
        idle();
        rd(14'h42, v);
        n_total++; if (v !== (TIMER_ON ? 32'd16 : 32'd0)) $display("FAIL timer_load got %h exp %h", v, TIMER_ON ? 32'd16 : 32'd0); else n_pass++;
        rd(14'h41, v);
        n_total++; if (v !== (TIMER_ON ? 32'h13 : 32'h0)) $display("FAIL timer_tcfg got %h exp %h", v, TIMER_ON ? 32'h13 : 32'h0); else n_pass++;
        for (int k = 1; k <= 16; k++) begin
            tick();
            rd(14'h42, v);
            n_total++;
            if (v !== (!TIMER_ON ? 32'd0 : k < 16 ? 32'(16 - k) : 32'd16)) $display("FAIL timer_tval k=%0d got %0d", k, v); else n_pass++;
            n_total++;
            if (int_req !== (TIMER_ON && k == 16)) $display("FAIL timer_int k=%0d got %b exp %b", k, int_req, TIMER_ON && k == 16); else n_pass++;
        end
        we0 = 1; waddr0 = 14'h44; wdata0 = 32'h1;
        tick();
        idle();
        rd(14'h5, v);
        n_total++; if (v[11] !== 1'b0 || int_req !== 1'b0) $display("FAIL ticlr got is11=%b int=%b exp 0/0", v[11], int_req); else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            we0 = 1'($urandom_range(0, 1));
            we1 = 1'($urandom_range(0, 1));
            waddr0 = 14'(addr_tab[$urandom_range(0, 18)]);
            waddr1 = ($urandom_range(0, 3) == 0) ? waddr0 : 14'(addr_tab[$urandom_range(0, 18)]);
            wdata0 = $urandom;
            wdata1 = $urandom;
            if (waddr0 == 14'h41) wdata0 = wdata0 & 32'h0000_00FF;
            if (waddr1 == 14'h41) wdata1 = wdata1 & 32'h0000_00FF;
            excp_flush = ($urandom_range(0, 9) == 0);
            ertn_flush = ($urandom_range(0, 7) == 0);
            excp_tlbrefill = 1'($urandom_range(0, 1));
            va_error = 1'($urandom_range(0, 1));
            csr_era = $urandom;
            bad_va = $urandom;
            csr_ecode = ($urandom_range(0, 3) == 0) ? 6'h3F : 6'($urandom);
            csr_esubcode = 9'($urandom);
            hw_int = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
            ipi = ($urandom_range(0, 7) == 0);
            rd(14'(addr_tab[$urandom_range(0, 18)]), v);
            n_total++; if (v !== model_read(int'(raddr))) $display("FAIL rand_rdata[%h] got %h exp %h", raddr, v, model_read(int'(raddr))); else n_pass++;
            v = excp_flush ? (excp_tlbrefill ? model_read('h88) : model_read('hC)) : ertn_flush ? model_read('h6) : 32'h0;
            n_total++; if (redirect_pc !== v) $display("FAIL rand_redirect got %h exp %h", redirect_pc, v); else n_pass++;
            n_total++; if (int_req !== model_int()) $display("FAIL rand_int_req got %b exp %b", int_req, model_int()); else n_pass++;
            v = model_read('h0);
            n_total++; if ({da, plv} !== {v[3], v[1:0]}) $display("FAIL rand_da_plv got %b exp %b", {da, plv}, {v[3], v[1:0]}); else n_pass++;
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_excp();
        test_ertn();
        test_tlbrefill();
        test_dual_write();
        test_timer();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
